clk_reset_sequencer: RTL and testbench

Board-level clock-enable and reset sequencing block that sits between the FPGA pins and the SoC. It filters the raw reset push-button (synchronise, then debounce) and holds every domain in reset for a programmable power-on interval. It then releases a configurable number of reset domains in staggered order and generates a divided clock-enable plus a legacy divided clock, so the SoC can run from the board clock without a toggled fabric clock.

---
 rtl/clk_reset_sequencer_if.sv | 37 +++
 rtl/clk_reset_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_clk_reset_sequencer.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_reset_sequencer_if.sv
// Board-side bundle of the reset sequencer: the raw button going in and the
// sequenced resets, clock enable and status coming out.
// The sequencer owns the master side; the SoC/board harness owns the slave side.

interface clk_reset_sequencer_if #(
   parameter int NUM_DOMAINS = 2
);

   logic                   btn_reset;
   logic                   ce_o;
   logic                   clk_div_o;
   logic [NUM_DOMAINS-1:0] rst_o;
   logic                   btn_db_o;
   logic                   ready_o;
   logic [7:0]             reset_count_o;

   modport master (
      input  btn_reset,
      output ce_o,
      output clk_div_o,
      output rst_o,
      output btn_db_o,
      output ready_o,
      output reset_count_o
   );

   modport slave (
      output btn_reset,
      input  ce_o,
      input  clk_div_o,
      input  rst_o,
      input  btn_db_o,
      input  ready_o,
      input  reset_count_o
   );

endinterface

// File: rtl/clk_reset_sequencer.sv
// Board-level reset sequencer: synchronises and debounces the reset button,
// holds all domains in reset for POR_CYCLES, releases NUM_DOMAINS resets in
// ascending order STAGGER_CYCLES apart, and produces a free-running clock
// enable plus a legacy divided clock.
//
// Every flop resets to 0. The domain resets are stored inverted (a 1 means
// "released"), the FSM encodes HOLD as 0 and the button path is normalised
// so that "not pressed" is 0. The all-zero configuration state therefore is
// the reset state, and the sequence runs from bitstream load without any
// reset pulse.

module clk_reset_sequencer #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int POR_CYCLES      = 20,
   parameter int NUM_DOMAINS     = 2,
   parameter int STAGGER_CYCLES  = 4,
   parameter int CLK_DIV         = 2,
   parameter bit BTN_ACTIVE_HIGH = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   clk_reset_sequencer_if.master bus
);

   // Counter widths: $clog2 of each limit, never below one bit.
   localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int HOLD_W = (POR_CYCLES > 1)      ? $clog2(POR_CYCLES)      : 1;
   localparam int STAG_W = (STAGGER_CYCLES > 1)  ? $clog2(STAGGER_CYCLES)  : 1;
   localparam int DIV_W  = (CLK_DIV > 1)         ? $clog2(CLK_DIV)         : 1;

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(POR_CYCLES - 1);
   localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER_CYCLES - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);

   localparam logic [NUM_DOMAINS-1:0] NONE_RELEASED = '0;
   localparam logic [NUM_DOMAINS-1:0] ALL_RELEASED  = '1;
   localparam logic [NUM_DOMAINS-1:0] FIRST_DOMAIN  = NUM_DOMAINS'(1);

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   // Button path
   logic                   btn_norm;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   btn_sync;
   logic [DB_W-1:0]        db_cnt_q;
   logic [DB_W-1:0]        db_cnt_d;
   logic                   btn_db_q;
   logic                   btn_db_d;
   logic                   btn_db_prev_q;
   logic                   press;

   // Press counter
   logic [7:0]             press_cnt_q;
   logic [7:0]             press_cnt_d;

   // Sequencing FSM
   state_t                 state_q;
   logic [HOLD_W-1:0]      hold_cnt_q;
   logic [STAG_W-1:0]      stag_cnt_q;
   logic [NUM_DOMAINS-1:0] released_q;
   logic [NUM_DOMAINS-1:0] released_next;
   logic                   ready_q;

   // Clock divider
   logic [DIV_W-1:0]       div_cnt_q;
   logic [DIV_W-1:0]       div_cnt_d;
   logic                   ce;
   logic                   clk_div_q;

   // Fold the button polarity so that 1 always means "pressed".
   assign btn_norm = BTN_ACTIVE_HIGH ? bus.btn_reset : ~bus.btn_reset;
   assign btn_sync = sync_q[SYNC_STAGES-1];

   // Synchroniser chain for the asynchronous button; idles at "not pressed".
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_norm};
      end
   end

   // Debounce: count consecutive cycles where the synchronised level differs
   // from the accepted level; accept it once the run is long enough.
   always_comb begin
      db_cnt_d = db_cnt_q;
      btn_db_d = btn_db_q;
      if (btn_sync == btn_db_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         db_cnt_d = '0;
         btn_db_d = btn_sync;
      end else begin
         db_cnt_d = db_cnt_q + DB_W'(1);
      end
   end

   // Debounce state and the delayed copy used for press edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         db_cnt_q      <= '0;
         btn_db_q      <= 1'b0;
         btn_db_prev_q <= 1'b0;
      end else begin
         db_cnt_q      <= db_cnt_d;
         btn_db_q      <= btn_db_d;
         btn_db_prev_q <= btn_db_q;
      end
   end

   // A press is accepted in the cycle after the debounced level rises.
   assign press = btn_db_q & ~btn_db_prev_q;

   // Saturating count of accepted presses.
   always_comb begin
      press_cnt_d = press_cnt_q;
      if (press && (press_cnt_q != 8'hFF)) begin
         press_cnt_d = press_cnt_q + 8'd1;
      end
   end

   // Press counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         press_cnt_q <= 8'd0;
      end else begin
         press_cnt_q <= press_cnt_d;
      end
   end

   // Next release pattern: one more domain released, lowest bit first.
   assign released_next = (released_q << 1) | FIRST_DOMAIN;

   // Sequencing FSM: HOLD for POR_CYCLES idle cycles, release domains one
   // STAGGER_CYCLES apart, then RUN until the next accepted press.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_HOLD;
         hold_cnt_q <= '0;
         stag_cnt_q <= '0;
         released_q <= NONE_RELEASED;
         ready_q    <= 1'b0;
      end else if (press) begin
         state_q    <= ST_HOLD;
         hold_cnt_q <= '0;
         stag_cnt_q <= '0;
         released_q <= NONE_RELEASED;
         ready_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_HOLD: begin
               released_q <= NONE_RELEASED;
               ready_q    <= 1'b0;
               stag_cnt_q <= '0;
               if (btn_db_q) begin
                  // Button still held down: keep the hold interval from starting.
                  hold_cnt_q <= '0;
               end else if (hold_cnt_q == HOLD_LAST) begin
                  hold_cnt_q <= '0;
                  if (NUM_DOMAINS == 1) begin
                     state_q    <= ST_RUN;
                     released_q <= ALL_RELEASED;
                     ready_q    <= 1'b1;
                  end else begin
                     state_q    <= ST_RELEASE;
                     released_q <= FIRST_DOMAIN;
                  end
               end else begin
                  hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
               end
            end

            ST_RELEASE: begin
               hold_cnt_q <= '0;
               if (stag_cnt_q == STAG_LAST) begin
                  stag_cnt_q <= '0;
                  released_q <= released_next;
                  if (released_next == ALL_RELEASED) begin
                     state_q <= ST_RUN;
                     ready_q <= 1'b1;
                  end
               end else begin
                  stag_cnt_q <= stag_cnt_q + STAG_W'(1);
               end
            end

            ST_RUN: begin
               hold_cnt_q <= '0;
               stag_cnt_q <= '0;
               released_q <= ALL_RELEASED;
               ready_q    <= 1'b1;
            end

            default: begin
               state_q    <= ST_HOLD;
               hold_cnt_q <= '0;
               stag_cnt_q <= '0;
               released_q <= NONE_RELEASED;
               ready_q    <= 1'b0;
            end
         endcase
      end
   end

   // Divider wraps at CLK_DIV-1. The enable is gated by reset so that it is
   // low while reset is applied and, with CLK_DIV=1, high from the first
   // cycle after reset.
   assign div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
   assign ce        = (div_cnt_q == DIV_LAST) && !reset;

   // Free-running divider and the legacy divided clock toggled on each enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt_q <= '0;
         clk_div_q <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         clk_div_q <= clk_div_q ^ ce;
      end
   end

   assign bus.ce_o          = ce;
   assign bus.clk_div_o     = clk_div_q;
   assign bus.rst_o         = ~released_q;
   assign bus.btn_db_o      = btn_db_q;
   assign bus.ready_o       = ready_q;
   assign bus.reset_count_o = press_cnt_q;

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// Bench for clk_reset_sequencer. Three instances share one clock:
//   A: main configuration (CLK_DIV=2, active-high button, driven reset)
//   B: CLK_DIV=3 with an active-low button idling at 1
//   C: CLK_DIV=1 with reset tied low from power-up
// Expected values are queued with the cycle they are due in; a negedge
// monitor pops and compares them.

module tb_clk_reset_sequencer;

   localparam int ND = 3;

   localparam int A_RST = 0;
   localparam int A_RDY = 1;
   localparam int A_DB  = 2;
   localparam int A_CNT = 3;
   localparam int A_CE  = 4;
   localparam int A_CKD = 5;
   localparam int B_RST = 6;
   localparam int B_RDY = 7;
   localparam int B_DB  = 8;
   localparam int B_CNT = 9;
   localparam int B_CE  = 10;
   localparam int B_CKD = 11;
   localparam int C_RST = 12;
   localparam int C_RDY = 13;
   localparam int C_CE  = 14;
   localparam int C_CKD = 15;

   typedef struct {
      int          cyc;
      int          sel;
      int unsigned val;
   } exp_t;

   logic        clk = 1'b1;
   logic        reset_a;
   logic        reset_b;
   logic        reset_c;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_err = 0;
   exp_t        sb[$];
   int unsigned cnt_model;
   int          t;

   clk_reset_sequencer_if #(.NUM_DOMAINS(ND)) if_a ();
   clk_reset_sequencer_if #(.NUM_DOMAINS(ND)) if_b ();
   clk_reset_sequencer_if #(.NUM_DOMAINS(ND)) if_c ();

   clk_reset_sequencer #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .POR_CYCLES(20), .NUM_DOMAINS(ND),
      .STAGGER_CYCLES(4), .CLK_DIV(2), .BTN_ACTIVE_HIGH(1'b1)
   ) dut_a (.clk(clk), .reset(reset_a), .bus(if_a.master));

   clk_reset_sequencer #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .POR_CYCLES(20), .NUM_DOMAINS(ND),
      .STAGGER_CYCLES(4), .CLK_DIV(3), .BTN_ACTIVE_HIGH(1'b0)
   ) dut_b (.clk(clk), .reset(reset_b), .bus(if_b.master));

   clk_reset_sequencer #(
      .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .POR_CYCLES(20), .NUM_DOMAINS(ND),
      .STAGGER_CYCLES(4), .CLK_DIV(1), .BTN_ACTIVE_HIGH(1'b1)
   ) dut_c (.clk(clk), .reset(reset_c), .bus(if_c.master));

   always #5 clk = ~clk;

   // Cycle n spans from the n-th rising edge to the next one.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic string sel_name(input int sel);
      case (sel)
         A_RST: return "A.rst_o";
         A_RDY: return "A.ready_o";
         A_DB:  return "A.btn_db_o";
         A_CNT: return "A.reset_count_o";
         A_CE:  return "A.ce_o";
         A_CKD: return "A.clk_div_o";
         B_RST: return "B.rst_o";
         B_RDY: return "B.ready_o";
         B_DB:  return "B.btn_db_o";
         B_CNT: return "B.reset_count_o";
         B_CE:  return "B.ce_o";
         B_CKD: return "B.clk_div_o";
         C_RST: return "C.rst_o";
         C_RDY: return "C.ready_o";
         C_CE:  return "C.ce_o";
         default: return "C.clk_div_o";
      endcase
   endfunction

   function automatic int unsigned probe(input int sel);
      case (sel)
         A_RST: return 32'(if_a.rst_o);
         A_RDY: return 32'(if_a.ready_o);
         A_DB:  return 32'(if_a.btn_db_o);
         A_CNT: return 32'(if_a.reset_count_o);
         A_CE:  return 32'(if_a.ce_o);
         A_CKD: return 32'(if_a.clk_div_o);
         B_RST: return 32'(if_b.rst_o);
         B_RDY: return 32'(if_b.ready_o);
         B_DB:  return 32'(if_b.btn_db_o);
         B_CNT: return 32'(if_b.reset_count_o);
         B_CE:  return 32'(if_b.ce_o);
         B_CKD: return 32'(if_b.clk_div_o);
         C_RST: return 32'(if_c.rst_o);
         C_RDY: return 32'(if_c.ready_o);
         C_CE:  return 32'(if_c.ce_o);
         default: return 32'(if_c.clk_div_o);
      endcase
   endfunction

   task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic expect_at(input int c, input int sel, input int unsigned v);
      exp_t e;
      e.cyc = c;
      e.sel = sel;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic exp_a(input int c, input int unsigned r, input int unsigned rdy);
      expect_at(c, A_RST, r);
      expect_at(c, A_RDY, rdy);
   endtask

   task automatic goto(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Scoreboard drain: compare every entry due in the current cycle.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == cyc) begin
            check_val($sformatf("%s@%0d", sel_name(sb[i].sel), cyc), probe(sb[i].sel), sb[i].val);
            sb.delete(i);
         end
      end
   end

   initial begin
      reset_a = 1'b1;
      reset_b = 1'b1;
      reset_c = 1'b0;
      if_a.btn_reset = 1'b0;
      if_b.btn_reset = 1'b1;
      if_c.btn_reset = 1'b0;

      // C: power-up with no reset pulse, CLK_DIV=1.
      expect_at(0, C_RST, 7);  expect_at(0, C_RDY, 0);
      for (int c = 0; c < 4; c++) begin
         expect_at(c, C_CE, 1);
         expect_at(c, C_CKD, c % 2);
      end
      expect_at(19, C_RST, 7);
      expect_at(20, C_RST, 6);
      expect_at(27, C_RST, 4); expect_at(27, C_RDY, 0);
      expect_at(28, C_RST, 0); expect_at(28, C_RDY, 1);

      // A: state while reset is held.
      exp_a(3, 7, 0);
      expect_at(3, A_CE, 0);  expect_at(3, A_CKD, 0);
      expect_at(3, A_DB, 0);  expect_at(3, A_CNT, 0);

      // A: release sequence, reset low from cycle 5.
      exp_a(5, 7, 0);  exp_a(24, 7, 0); exp_a(25, 6, 0); exp_a(28, 6, 0);
      exp_a(29, 4, 0); exp_a(32, 4, 0); exp_a(33, 0, 1);
      // A: CLK_DIV=2 enable and divided clock.
      expect_at(5, A_CE, 0); expect_at(6, A_CE, 1); expect_at(7, A_CE, 0); expect_at(8, A_CE, 1);
      expect_at(6, A_CKD, 0); expect_at(7, A_CKD, 1); expect_at(9, A_CKD, 0);

      // B: CLK_DIV=3 enable in relative cycles 2,5,8; divided clock period 6.
      for (int c = 0; c < 9; c++) expect_at(5 + c, B_CE, (c % 3 == 2) ? 1 : 0);
      expect_at(7, B_CKD, 0);  expect_at(8, B_CKD, 1); expect_at(10, B_CKD, 1);
      expect_at(11, B_CKD, 0); expect_at(14, B_CKD, 1);
      // B: active-low button idling at 1 is never a press.
      expect_at(32, B_RDY, 0); expect_at(33, B_RDY, 1);
      expect_at(500, B_RST, 0); expect_at(500, B_RDY, 1);
      expect_at(500, B_DB, 0);  expect_at(500, B_CNT, 0);

      goto(5);
      reset_a = 1'b0;
      reset_b = 1'b0;

      // A: 5-cycle glitch in RUN is rejected.
      expect_at(47, A_DB, 0);
      expect_at(50, A_DB, 0); exp_a(50, 0, 1); expect_at(50, A_CNT, 0);
      expect_at(60, A_DB, 0); exp_a(60, 0, 1); expect_at(60, A_CNT, 0);
      goto(40);  if_a.btn_reset = 1'b1;
      goto(45);  if_a.btn_reset = 1'b0;

      // A: held press, raw high cycles 100-129.
      expect_at(109, A_DB, 0);
      expect_at(110, A_DB, 1); exp_a(110, 0, 1); expect_at(110, A_CNT, 0);
      exp_a(111, 7, 0); expect_at(111, A_CNT, 1);
      expect_at(139, A_DB, 1); expect_at(140, A_DB, 0);
      exp_a(159, 7, 0); exp_a(160, 6, 0); exp_a(163, 6, 0);
      exp_a(164, 4, 0); exp_a(167, 4, 0); exp_a(168, 0, 1);
      goto(100); if_a.btn_reset = 1'b1;
      goto(130); if_a.btn_reset = 1'b0;

      // A: reset during RUN, then a one-cycle reset pulse mid-release.
      expect_at(199, A_CNT, 1);
      exp_a(201, 7, 0); expect_at(201, A_CNT, 0);
      expect_at(203, A_CE, 0); expect_at(203, A_CKD, 0);
      expect_at(203, A_DB, 0); expect_at(203, A_CNT, 0);
      exp_a(231, 4, 0); exp_a(232, 7, 0);
      exp_a(251, 7, 0); exp_a(252, 6, 0); exp_a(256, 4, 0);
      exp_a(259, 4, 0); exp_a(260, 0, 1);
      goto(200); reset_a = 1'b1;
      goto(205); reset_a = 1'b0;
      goto(231); reset_a = 1'b1;
      goto(232); reset_a = 1'b0;

      // A: reset coincides with the edge that would accept a press.
      expect_at(289, A_DB, 0); expect_at(289, A_CNT, 0);
      expect_at(290, A_DB, 0); expect_at(290, A_CNT, 0); exp_a(290, 7, 0);
      expect_at(291, A_CNT, 0);
      expect_at(300, A_DB, 0); expect_at(300, A_CNT, 0);
      exp_a(310, 6, 0); exp_a(314, 4, 0);
      // A: press during RELEASE restarts HOLD and counts.
      exp_a(315, 4, 0); expect_at(315, A_CNT, 0); expect_at(315, A_DB, 1);
      exp_a(316, 7, 0); expect_at(316, A_CNT, 1);
      expect_at(330, A_DB, 1); expect_at(331, A_DB, 0);
      exp_a(350, 7, 0); exp_a(351, 6, 0); exp_a(355, 4, 0); exp_a(359, 0, 1);
      goto(280); if_a.btn_reset = 1'b1;
      goto(289); reset_a = 1'b1;
      goto(290); reset_a = 1'b0; if_a.btn_reset = 1'b0;
      goto(305); if_a.btn_reset = 1'b1;
      goto(321); if_a.btn_reset = 1'b0;

      // A: 260 further presses, count saturates at 255.
      cnt_model = 1;
      for (int i = 0; i < 260; i++) begin
         t = 400 + 20 * i;
         if (i == 0) begin
            expect_at(t + 9, A_DB, 0);
            expect_at(t + 10, A_DB, 1);
         end
         if (i == 253) expect_at(t + 5, A_CNT, cnt_model);
         cnt_model = (cnt_model >= 255) ? 255 : cnt_model + 1;
         if (i < 2 || i > 251) expect_at(t + 11, A_CNT, cnt_model);
         goto(t);      if_a.btn_reset = 1'b1;
         goto(t + 10); if_a.btn_reset = 1'b0;
      end
      exp_a(5627, 4, 0);
      exp_a(5628, 0, 1);
      expect_at(5628, A_CNT, 255);

      goto(5640);
      foreach (sb[i]) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s never sampled (due cycle %0d), expected %0d", sel_name(sb[i].sel), sb[i].cyc, sb[i].val);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
